div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle integer divide unit for the execute stage. Takes the operands of an M-extension divide or remainder instruction (DIV, DIVU, REM, REMU) and runs a radix-2 restoring division, one quotient bit per cycle. It reports busy so the pipeline stalls, and returns a one-cycle-valid result tagged with the destination register. Divide-by-zero and signed overflow bypass the iteration loop and return RISC-V-mandated results.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  request; sampled only when ready_o=1
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  input  XLEN  rs1 value
- divisor_i  input  XLEN  rs2 value
- rd_i  input  5  destination register tag
- flush_i  input  1  abort in-flight operation (branch/jump flush)
- ready_o  output  1  high in IDLE only
- busy_o  output  1  high in CALC, FIX, DONE; pipeline stall request
- valid_o  output  1  one-cycle result strobe
- result_o  output  XLEN  quotient or remainder; held until next valid
- rd_o  output  5  tag captured at start; held until next valid

## Operation
- States: IDLE, CALC, FIX, DONE. Reset -> IDLE.
- IDLE, start_i=1: latch op, rd, operand signs, and divisor==0 / overflow flags. Overflow means a DIV or REM op with dividend 0x80000000 and divisor 0xFFFFFFFF.
  - Special case (divisor zero or overflow): load result directly, go to DONE.
  - Otherwise: load magnitudes, go to CALC. Signed ops use two's-complement absolute values; unsigned ops use raw values. Also clear the remainder register and set the iteration counter to XLEN-1.
- Special-case results:
  - DIV/DIVU by zero: 0xFFFFFFFF.
  - REM/REMU by zero: dividend.
  - DIV overflow: 0x80000000.
  - REM overflow: 0.
- CALC, each cycle:
  - {rem,quo} shifts left one bit.
  - Trial = rem - divisor (XLEN+1 bits).
  - If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - Counter decrements. When the counter reaches 0 during the current iteration, go to FIX.
- FIX: apply signs, load result_o, go to DONE.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the dividend sign.
  - Unsigned results pass through unchanged.
- DONE: valid_o=1 for exactly this cycle, then IDLE.
- start_i outside IDLE is ignored. It is neither queued nor acknowledged.
- flush_i in CALC or FIX: next state is IDLE, and valid_o is not asserted for that operation. result_o and rd_o keep their previous values.
- flush_i in DONE or IDLE has no effect; a result in DONE is still delivered.
- Simultaneous start_i and flush_i in IDLE: start wins.

## Timing
- Reset values:
  - ready_o=1, busy_o=0, valid_o=0.
  - result_o=0, rd_o=0.
  - Internal counter, remainder and quotient registers all zero.
- Reset mid-operation immediately returns the block to IDLE with the values above; no valid is produced.
- Normal path, with start_i sampled at the end of cycle 0:
  - busy_o high in cycles 1..34.
  - CALC occupies cycles 1..32, FIX cycle 33, DONE cycle 34.
  - valid_o high in cycle 34 only.
  - ready_o returns high in cycle 35, which is the earliest cycle a new start is accepted.
- Special-case path: busy_o and valid_o both high in cycle 1; ready_o high in cycle 2.
- flush_i high in cycle k (CALC/FIX): busy_o low and ready_o high from cycle k+1.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
- DIVU 100/7 -> result_o=14, valid_o in cycle 34; REMU 100/7 -> result_o=2; rd_i=5 -> rd_o=5.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD (-3); REM 0xFFFFFFF9/2 -> 0xFFFFFFFF (-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
- DIVU 5/0 -> 0xFFFFFFFF, valid_o in cycle 1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both in cycle 1.
- Start DIVU 1000/3:
  - start_i pulsed again in cycle 5 with other operands -> ignored; result_o=333 in cycle 34.
  - Back-to-back start in cycle 35 -> accepted.
- Start in cycle 0, flush_i in cycle 10:
  - busy_o=0 and ready_o=1 from cycle 11; no valid_o; result_o unchanged.
  - A new DIVU 9/3 started in cycle 11 -> 3 in cycle 45.
- rst_i asserted asynchronously in cycle 20 of an operation -> all outputs take their reset values before the next edge; no valid_o ever appears for that operation.

Source files
------------

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, next_state;

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [4:0]      rd_q;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    logic            signed_op;
    logic            is_rem;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] fix_result;

    // Operand decode used only at the accepting edge in IDLE
    always_comb begin
        signed_op    = ~op_i[0];
        is_rem       = op_i[1];
        div_zero     = (divisor_i == '0);
        overflow     = signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (divisor_i == '1);
        special      = div_zero || overflow;
        dividend_mag = (signed_op && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
        divisor_mag  = (signed_op && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
        if (div_zero)
            special_result = is_rem ? dividend_i : '1;
        else
            special_result = is_rem ? '0 : dividend_i;
    end

    // One restoring step: a trial result with the top bit set means rem < divisor
    always_comb begin
        rem_shift  = {rem_q, quo_q[XLEN-1]};
        trial      = rem_shift - {1'b0, dvsr_q};
        trial_ok   = ~trial[XLEN];
        rem_next   = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next   = {quo_q[XLEN-2:0], trial_ok};
        fix_result = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quo_q ? -quo_q : quo_q);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_i)
                    next_state = special ? DONE : CALC;
            end
            CALC: begin
                if (flush_i)
                    next_state = IDLE;
                else if (cnt_q == '0)
                    next_state = FIX;
            end
            FIX: begin
                next_state = flush_i ? IDLE : DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Status flags are registered from the next state so they line up with it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            ready_o <= (next_state == IDLE);
            busy_o  <= (next_state != IDLE);
            valid_o <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            rd_q      <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            rd_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        rd_q      <= rd_i;
                        is_rem_q  <= is_rem;
                        neg_quo_q <= signed_op && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_rem_q <= signed_op && dividend_i[XLEN-1];
                        if (special) begin
                            result_o <= special_result;
                            rd_o     <= rd_i;
                        end else begin
                            quo_q  <= dividend_mag;
                            dvsr_q <= divisor_mag;
                            rem_q  <= '0;
                            cnt_q  <= CW'(XLEN-1);
                        end
                    end
                end
                CALC: begin
                    if (!flush_i) begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    if (!flush_i) begin
                        result_o <= fix_result;
                        rd_o     <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
module tb_div_sequencer;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    div_sequencer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .rd_i       (rd),
        .flush_i    (flush),
        .ready_o    (ready),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result),
        .rd_o       (rd_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid === 1'b1)
            valid_cnt <= valid_cnt + 1;
    end

    // Called just after the edge that ends the start cycle; 'first' is the current cycle index
    task automatic wait_valid(input int first, output int cyc);
        cyc = first;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) break;
            if (cyc >= 120) begin
                checks++;
                errors++;
                $display("FAIL wait_valid timeout: valid_o never seen, required within 120 cycles");
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_start(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] r);
        op = o; dividend = a; divisor = b; rd = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, output logic [31:0] res,
                          output logic [4:0] rdo, output int cyc);
        drive_start(o, a, b, r);
        wait_valid(1, cyc);
        res = result;
        rdo = rd_out;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (rd_out !== 5'd0)  begin errors++; $display("FAIL reset_rd got %0d want 0", rd_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        logic [31:0] res; logic [4:0] r; int cyc;
        drive_start(OP_DIVU, 32'd100, 32'd7, 5'd5);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL divu_busy_c1 got busy=%b ready=%b want 1/0", busy, ready); end
        wait_valid(1, cyc);
        res = result; r = rd_out;
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result got %0d want 14", res); end
        checks++; if (cyc != 34)      begin errors++; $display("FAIL divu_latency got %0d want 34", cyc); end
        checks++; if (r !== 5'd5)     begin errors++; $display("FAIL divu_rd got %0d want 5", r); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL divu_ready_c35 got ready=%b busy=%b want 1/0", ready, busy); end
        run_op(OP_REMU, 32'd100, 32'd7, 5'd9, res, r, cyc);
        checks++; if (res !== 32'd2)  begin errors++; $display("FAIL remu_result got %0d want 2", res); end
        checks++; if (r !== 5'd9)     begin errors++; $display("FAIL remu_rd got %0d want 9", r); end
    endtask

    task automatic test_signed;
        logic [31:0] res; logic [4:0] r; int cyc;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, res, r, cyc);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_dividend got %h want fffffffd", res); end
        checks++; if (cyc != 34)             begin errors++; $display("FAIL div_latency got %0d want 34", cyc); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, res, r, cyc);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg_dividend got %h want ffffffff", res); end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3, res, r, cyc);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_divisor got %h want fffffffd", res); end
        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd3, res, r, cyc);
        checks++; if (res !== 32'd1)         begin errors++; $display("FAIL rem_neg_divisor got %h want 1", res); end
    endtask

    task automatic test_special;
        logic [31:0] res; logic [4:0] r; int cyc;
        drive_start(OP_DIVU, 32'd5, 32'd0, 5'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy_c1 got %b want 1", busy); end
        wait_valid(1, cyc);
        res = result; r = rd_out;
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero got %h want ffffffff", res); end
        checks++; if (cyc != 1)              begin errors++; $display("FAIL divu_by_zero_latency got %0d want 1", cyc); end
        checks++; if (r !== 5'd4)            begin errors++; $display("FAIL divu_by_zero_rd got %0d want 4", r); end
        checks++; if (ready !== 1'b1)        begin errors++; $display("FAIL dz_ready_c2 got %b want 1", ready); end
        run_op(OP_REM, 32'd5, 32'd0, 5'd6, res, r, cyc);
        checks++; if (res !== 32'd5)         begin errors++; $display("FAIL rem_by_zero got %h want 5", res); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, res, r, cyc);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h want 80000000", res); end
        checks++; if (cyc != 1)              begin errors++; $display("FAIL div_overflow_latency got %0d want 1", cyc); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, res, r, cyc);
        checks++; if (res !== 32'd0)         begin errors++; $display("FAIL rem_overflow got %h want 0", res); end
        checks++; if (cyc != 1)              begin errors++; $display("FAIL rem_overflow_latency got %0d want 1", cyc); end
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, res, r, cyc);
        checks++; if (res !== 32'd0 || cyc != 34) begin errors++; $display("FAIL divu_no_overflow got %h at %0d want 0 at 34", res, cyc); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res; logic [4:0] r; int cyc;
        drive_start(OP_DIVU, 32'd1000, 32'd3, 5'd10);
        repeat (4) begin @(posedge clk); #1; end
        // now in cycle 5: a second request must be ignored
        drive_start(OP_DIVU, 32'd50, 32'd5, 5'd20);
        wait_valid(6, cyc);
        res = result; r = rd_out;
        checks++; if (res !== 32'd333) begin errors++; $display("FAIL ignore_start_result got %0d want 333", res); end
        checks++; if (cyc != 34)       begin errors++; $display("FAIL ignore_start_latency got %0d want 34", cyc); end
        checks++; if (r !== 5'd10)     begin errors++; $display("FAIL ignore_start_rd got %0d want 10", r); end
        run_op(OP_DIVU, 32'd20, 32'd4, 5'd11, res, r, cyc);
        checks++; if (res !== 32'd5 || cyc != 34) begin errors++; $display("FAIL back_to_back got %0d at %0d want 5 at 34", res, cyc); end
    endtask

    task automatic test_flush;
        logic [31:0] res; logic [4:0] r; int cyc; int vc;
        logic [31:0] prev_res; logic [4:0] prev_rd;
        prev_res = result; prev_rd = rd_out;
        vc = valid_cnt;
        drive_start(OP_DIVU, 32'd1000, 32'd3, 5'd12);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL flush_c11 got busy=%b ready=%b want 0/1", busy, ready); end
        checks++; if (result !== prev_res) begin errors++; $display("FAIL flush_result_kept got %h want %h", result, prev_res); end
        checks++; if (rd_out !== prev_rd)  begin errors++; $display("FAIL flush_rd_kept got %0d want %0d", rd_out, prev_rd); end
        run_op(OP_DIVU, 32'd9, 32'd3, 5'd13, res, r, cyc);
        checks++; if (res !== 32'd3) begin errors++; $display("FAIL after_flush_result got %0d want 3", res); end
        checks++; if (cyc + 11 != 45) begin errors++; $display("FAIL after_flush_cycle got %0d want 45", cyc + 11); end
        checks++; if (valid_cnt != vc + 1) begin errors++; $display("FAIL flush_no_valid got %0d pulses want 1", valid_cnt - vc); end
    endtask

    task automatic test_async_reset;
        int vc;
        drive_start(OP_DIVU, 32'd1000, 32'd3, 5'd14);
        repeat (19) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL async_reset_flags got r=%b b=%b v=%b want 1/0/0", ready, busy, valid); end
        checks++; if (result !== 32'd0 || rd_out !== 5'd0) begin errors++; $display("FAIL async_reset_data got %h/%0d want 0/0", result, rd_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        vc = valid_cnt;
        repeat (40) begin @(posedge clk); #1; end
        checks++; if (valid_cnt != vc) begin errors++; $display("FAIL async_reset_no_valid got %0d pulses want 0", valid_cnt - vc); end
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL async_reset_idle got ready=%b want 1", ready); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
